// File: rtl/iob_cfg_pkg.sv
// Shared types and constants for the IOB configuration loader.
package iob_cfg_pkg;

  localparam int unsigned IOB_W = 8;
  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

endpackage

// File: rtl/iob_cfg_shadow.sv
// Staging register file for one frame's IOB bytes; read out in parallel at commit.
module iob_cfg_shadow
  import iob_cfg_pkg::*;
#(
  parameter int unsigned NUM_IOB = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_IOB) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [IDX_W-1:0]         wr_idx_i,
  input  logic [IOB_W-1:0]         wr_data_i,
  output logic [IOB_W*NUM_IOB-1:0] rd_data_o
);

  logic [IOB_W*NUM_IOB-1:0] mem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else if (wr_en_i) begin
      for (int i = 0; i < int'(NUM_IOB); i++) begin
        if (wr_idx_i == IDX_W'(i)) begin
          mem_q[i*IOB_W +: IOB_W] <= wr_data_i;
        end
      end
    end
  end

  assign rd_data_o = mem_q;

endmodule

// File: rtl/iob_cfg_loader.sv
// Framed, checksummed byte-stream loader driving IOB switch enables.
// state | meaning
// IDLE  | waiting for the sync byte; other bytes are dropped
// LOAD  | storing data bytes into the shadow file, folding them into acc
// CHECK | next byte is the checksum; commit shadow on match, else flag error
module iob_cfg_loader
  import iob_cfg_pkg::*;
#(
  parameter int unsigned NUM_IOB   = 4,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               cfg_data,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic                     cfg_abort,
  output logic [IOB_W*NUM_IOB-1:0] sram_con_bit,
  output logic                     cfg_done,
  output logic                     cfg_err,
  output logic                     cfg_busy
);

  localparam int unsigned IDX_W = $clog2(NUM_IOB) + 1;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [7:0]               acc_q, acc_d;
  logic [IOB_W*NUM_IOB-1:0] sram_q, sram_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     ready_q;
  logic                     shadow_we;
  logic [IOB_W*NUM_IOB-1:0] shadow_rd;
  logic                     xfer;

  // Abort outranks any byte presented on the same edge.
  assign xfer = cfg_valid && ready_q && !cfg_abort;

  iob_cfg_shadow #(
    .NUM_IOB (NUM_IOB),
    .IDX_W   (IDX_W)
  ) u_shadow (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (shadow_we),
    .wr_idx_i  (idx_q),
    .wr_data_i (cfg_data),
    .rd_data_o (shadow_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (cfg_abort) begin
      state_d = ST_IDLE;
    end else if (xfer) begin
      unique case (state_q)
        ST_IDLE:  if (cfg_data == SYNC_BYTE) state_d = ST_LOAD;
        ST_LOAD:  if (idx_q == IDX_W'(NUM_IOB - 1)) state_d = ST_CHECK;
        ST_CHECK: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    idx_d     = idx_q;
    acc_d     = acc_q;
    sram_d    = sram_q;
    err_d     = err_q;
    done_d    = 1'b0;
    shadow_we = 1'b0;
    if (xfer) begin
      unique case (state_q)
        ST_IDLE: begin
          if (cfg_data == SYNC_BYTE) begin
            idx_d = '0;
            acc_d = '0;
            err_d = 1'b0;
          end
        end
        ST_LOAD: begin
          shadow_we = 1'b1;
          acc_d     = acc_q ^ cfg_data;
          idx_d     = idx_q + IDX_W'(1);
        end
        ST_CHECK: begin
          if (cfg_data == acc_q) begin
            sram_d = shadow_rd;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      acc_q   <= '0;
      sram_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      sram_q  <= sram_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= 1'b1;
    end
  end

  assign cfg_ready    = ready_q;
  assign sram_con_bit = sram_q;
  assign cfg_done     = done_q;
  assign cfg_err      = err_q;
  assign cfg_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_iob_cfg_loader.sv
// Scoreboard bench for iob_cfg_loader: frame-level reference model plus per-cycle monitor.
module tb_iob_cfg_loader;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [7:0]     cfg_data = 8'h00;
  logic           cfg_valid = 1'b0;
  logic           cfg_abort = 1'b0;
  logic           cfg_ready;
  logic [8*N-1:0] sram_con_bit;
  logic           cfg_done;
  logic           cfg_err;
  logic           cfg_busy;

  int n_cmp = 0;
  int n_mis = 0;
  int n_done = 0;

  always #5 clk = ~clk;

  iob_cfg_loader #(.NUM_IOB(N), .SYNC_BYTE(8'hA5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_data     (cfg_data),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_abort    (cfg_abort),
    .sram_con_bit (sram_con_bit),
    .cfg_done     (cfg_done),
    .cfg_err      (cfg_err),
    .cfg_busy     (cfg_busy)
  );

  // Reference model: a frame is a sync byte, a list of N data bytes, then their XOR.
  bit             m_ready = 0;
  bit             m_inframe = 0;
  bit             m_err = 0;
  bit             m_done = 0;
  logic [8*N-1:0] m_sram = '0;
  logic [7:0]     m_buf[$];
  logic [8*N-1:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    logic [7:0] x;
    if (!rst_n) begin
      m_ready = 0; m_inframe = 0; m_err = 0; m_done = 0; m_sram = '0;
      m_buf.delete();
    end else begin
      m_done = 0;
      if (cfg_abort) begin
        m_inframe = 0;
      end else if (cfg_valid && m_ready) begin
        if (!m_inframe) begin
          if (cfg_data == 8'hA5) begin
            m_inframe = 1; m_err = 0; m_buf.delete();
          end
        end else if (m_buf.size() < N) begin
          m_buf.push_back(cfg_data);
        end else begin
          x = 8'h00;
          foreach (m_buf[k]) x ^= m_buf[k];
          if (x == cfg_data) begin
            for (int k = 0; k < N; k++) m_sram[8*k +: 8] = m_buf[k];
            m_done = 1;
            exp_q.push_back(m_sram);
          end else begin
            m_err = 1;
          end
          m_inframe = 0;
        end
      end
      m_ready = 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every cycle; each cfg_done pops one expected commit.
  always @(negedge clk) begin
    logic [8*N-1:0] e;
    chk("ready", 32'(cfg_ready), 32'(m_ready));
    chk("busy", 32'(cfg_busy), 32'(m_inframe));
    chk("err", 32'(cfg_err), 32'(m_err));
    chk("done", 32'(cfg_done), 32'(m_done));
    chk("sram", sram_con_bit, m_sram);
    if (cfg_done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(cfg_done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("commit", sram_con_bit, e);
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic ab = 1'b0);
    @(negedge clk);
    cfg_data = b; cfg_valid = 1'b1; cfg_abort = ab;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cfg_valid = 1'b0; cfg_abort = 1'b0; cfg_data = $urandom_range(0, 255);
    end
  endtask

  task automatic maybe_gap();
    if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
  endtask

  task automatic rand_frame();
    logic [7:0] d, x;
    int ab_pos;
    repeat ($urandom_range(0, 2)) begin
      d = $urandom_range(0, 255);
      if (d == 8'hA5) d = 8'h5A;
      send(d); maybe_gap();
    end
    ab_pos = ($urandom_range(0, 7) == 0) ? $urandom_range(0, N) : -1;
    send(8'hA5); maybe_gap();
    x = 8'h00;
    for (int i = 0; i < N; i++) begin
      d = ($urandom_range(0, 5) == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
      x ^= d;
      send(d, (ab_pos == i) ? 1'b1 : 1'b0); maybe_gap();
    end
    if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
    send(x, (ab_pos == N) ? 1'b1 : 1'b0);
    maybe_gap();
  endtask

  initial begin
    int d0;
    idle(3);
    #2 rst_n = 1'b1;
    idle(2);

    send(8'hA5); send(8'h01); send(8'h02); send(8'h04); send(8'h08); send(8'h0F);
    idle(1);
    chk("good_frame", sram_con_bit, 32'h08040201);
    chk("good_err", 32'(cfg_err), 32'd0);

    send(8'hA5); send(8'h01); send(8'h02); send(8'h04); send(8'h08); send(8'h0E);
    idle(1);
    chk("bad_keep", sram_con_bit, 32'h08040201);
    chk("bad_err", 32'(cfg_err), 32'd1);

    send(8'h00); send(8'hFF); send(8'h3C);
    idle(1);
    chk("junk_busy", 32'(cfg_busy), 32'd0);
    send(8'hA5);
    idle(1);
    chk("sync_clears_err", 32'(cfg_err), 32'd0);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h44);
    idle(1);
    chk("after_junk", sram_con_bit, 32'h44332211);

    send(8'hA5); maybe_gap(); send(8'hA5); maybe_gap(); send(8'h00); maybe_gap();
    send(8'h00); idle(2); send(8'h00); maybe_gap(); send(8'hA5);
    idle(1);
    chk("a5_as_data", sram_con_bit, 32'h000000A5);

    d0 = n_done;
    send(8'hA5); send(8'h11); send(8'h22);
    @(negedge clk); cfg_valid = 1'b0; cfg_abort = 1'b1;
    send(8'hA5); send(8'h10); send(8'h20); send(8'h30); send(8'h40); send(8'h40);
    idle(1);
    chk("abort_new", sram_con_bit, 32'h40302010);
    chk("abort_done_cnt", 32'(n_done - d0), 32'd1);

    send(8'hA5); send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF); send(8'h00);
    idle(1);
    chk("all_ones", sram_con_bit, 32'hFFFFFFFF);
    send(8'hA5); send(8'h12); send(8'h34);
    idle(1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sram", sram_con_bit, 32'h0);
    chk("rst_busy", 32'(cfg_busy), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd0);
    idle(2);
    #2 rst_n = 1'b1;
    idle(2);

    repeat (60) rand_frame();

    idle(4);
    chk("pending_commits", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
